// File: rtl/bfm_model_2x2.sv
// Streaming 2x2 block-average video downscaler with AXI-Stream-style tuser/tlast sideband.
// Build option: define BFM_ROUNDING_EN for round-half-up averaging (default truncates).
module bfm_model_2x2 #(
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned MAX_WIDTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready
);
    localparam int unsigned PAIRS = MAX_WIDTH / 2;
    localparam int unsigned CW    = $clog2(MAX_WIDTH);
    localparam int unsigned SW    = D_WIDTH + 2;

    logic [CW-1:0]      r_col;
    logic               r_row_odd;
    logic               r_col_ovf;
    logic               r_sof_pend;
    logic [D_WIDTH-1:0] r_hold;
    logic [D_WIDTH:0]   r_line_buf [PAIRS];

    logic               w_xfer;
    logic [CW-1:0]      w_col;
    logic               w_row_odd;
    logic               w_ovf;
    logic               w_col_wrap;
    logic [CW-2:0]      w_pair;
    logic               w_buf_wr;
    logic               w_emit;
    logic [SW-1:0]      w_sum;
    logic [SW-1:0]      w_res;

    assign up_ready = !down_valid || down_ready;
    assign w_xfer   = up_valid && up_ready;

    // A start-of-frame pixel is always the top-left of a fresh frame
    assign w_col     = up_tuser ? '0 : r_col;
    assign w_row_odd = up_tuser ? 1'b0 : r_row_odd;
    assign w_ovf     = up_tuser ? 1'b0 : r_col_ovf;

    assign w_pair     = w_col[CW-1:1];
    assign w_col_wrap = (w_col == CW'(MAX_WIDTH - 1));
    assign w_buf_wr   = w_xfer && w_col[0] && !w_row_odd && !w_ovf;
    assign w_emit     = w_xfer && w_col[0] && w_row_odd && !w_ovf;

    assign w_sum = SW'(r_line_buf[w_pair]) + SW'(r_hold) + SW'(up_data);

`ifdef BFM_ROUNDING_EN
    assign w_res = w_sum + SW'(2);
`else
    assign w_res = w_sum;
`endif

    // Column/row tracking; r_col_ovf marks pixels past the line buffer depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row_odd <= 1'b0;
            r_col_ovf <= 1'b0;
        end else if (w_xfer) begin
            if (up_tlast) begin
                r_col     <= '0;
                r_row_odd <= !w_row_odd;
                r_col_ovf <= 1'b0;
            end else begin
                r_col     <= w_col_wrap ? '0 : w_col + CW'(1);
                r_row_odd <= w_row_odd;
                r_col_ovf <= w_ovf || w_col_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= '0;
            r_sof_pend <= 1'b0;
        end else begin
            if (w_xfer && !w_col[0]) begin
                r_hold <= up_data;
            end
            if (w_xfer && up_tuser) begin
                r_sof_pend <= 1'b1;
            end else if (w_emit) begin
                r_sof_pend <= 1'b0;
            end
        end
    end

    // Top-row horizontal pair sums; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_line_buf[w_pair] <= (D_WIDTH+1)'(r_hold) + (D_WIDTH+1)'(up_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
            down_tlast <= 1'b0;
            down_tuser <= 1'b0;
        end else if (w_emit) begin
            down_valid <= 1'b1;
            down_data  <= D_WIDTH'(w_res >> 2);
            down_tlast <= up_tlast;
            down_tuser <= r_sof_pend;
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bfm_model_2x2.sv
// Directed scoreboard bench for bfm_model_2x2; expected averages follow BFM_ROUNDING_EN.
module tb_bfm_model_2x2;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] up_data;
    logic       up_valid;
    logic       up_tlast;
    logic       up_tuser;
    logic       up_ready;
    logic [7:0] down_data;
    logic       down_valid;
    logic       down_tlast;
    logic       down_tuser;
    logic       down_ready;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    exp_t sb [$];

    bfm_model_2x2 dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_tlast   (up_tlast),
        .up_tuser   (up_tuser),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_tlast (down_tlast),
        .down_tuser (down_tuser),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] avg4(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d;
`ifdef BFM_ROUNDING_EN
        s = s + 2;
`endif
        return 8'(s >> 2);
    endfunction

    task automatic push(input logic [7:0] d, input logic u, input logic l);
        exp_t e;
        e.d = d;
        e.u = u;
        e.l = l;
        sb.push_back(e);
    endtask

    // Drive one pixel and return 1 time unit after the edge that accepted it
    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int n;
        n = 0;
        up_data  = d;
        up_tuser = u;
        up_tlast = l;
        up_valid = 1'b1;
        @(negedge clk);
        while (!up_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(up_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        up_valid = 1'b0;
        up_tuser = 1'b0;
        up_tlast = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(sb.size()), 0);
    endtask

    // 4x2 reference frame with latency checks on both outputs
    task automatic frame4x2(input string tag);
        send(8'd10, 1'b1, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        send(8'd40, 1'b0, 1'b1);
        send(8'd50, 1'b0, 1'b0);
        check({tag, "_pre_valid"}, 32'(down_valid), 0);
        push(8'd35, 1'b1, 1'b0);
        send(8'd60, 1'b0, 1'b0);
        check({tag, "_lat35_valid"}, 32'(down_valid), 1);
        check({tag, "_lat35_data"}, 32'(down_data), 35);
        send(8'd70, 1'b0, 1'b0);
        push(8'd55, 1'b0, 1'b1);
        send(8'd80, 1'b0, 1'b1);
        check({tag, "_lat55_valid"}, 32'(down_valid), 1);
        check({tag, "_lat55_data"}, 32'(down_data), 55);
        idle(1);
        drain({tag, "_drain"});
    endtask

    // Scoreboard: compare each output as it is accepted by the sink
    always @(negedge clk) begin
        if (!rst && down_valid && down_ready) begin
            if (sb.size() == 0) begin
                check("out_extra_valid", 32'(down_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(down_data), 32'(e.d));
                check("out_tuser", 32'(down_tuser), 32'(e.u));
                check("out_tlast", 32'(down_tlast), 32'(e.l));
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] row0 [8];
        logic [7:0] row1 [8];
        int         c0;

        rst        = 1'b1;
        up_data    = '0;
        up_valid   = 1'b0;
        up_tlast   = 1'b0;
        up_tuser   = 1'b0;
        down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(down_valid), 0);
        check("rst_data", 32'(down_data), 0);
        check("rst_tlast", 32'(down_tlast), 0);
        check("rst_tuser", 32'(down_tuser), 0);
        check("rst_up_ready", 32'(up_ready), 1);
        rst = 1'b0;
        idle(1);

        // Basic 4x2 frame
        frame4x2("s1");

        // Backpressure from the first output
        down_ready = 1'b0;
        send(8'd10, 1'b1, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        send(8'd40, 1'b0, 1'b1);
        send(8'd50, 1'b0, 1'b0);
        push(8'd35, 1'b1, 1'b0);
        send(8'd60, 1'b0, 1'b0);
        up_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_up_ready", 32'(up_ready), 0);
            check("bp_hold_valid", 32'(down_valid), 1);
            check("bp_hold_data", 32'(down_data), 35);
            check("bp_hold_tuser", 32'(down_tuser), 1);
            @(posedge clk);
            #1;
        end
        down_ready = 1'b1;
        send(8'd70, 1'b0, 1'b0);
        push(8'd55, 1'b0, 1'b1);
        send(8'd80, 1'b0, 1'b1);
        idle(1);
        drain("bp_drain");

        // Odd height 2x3 of 100s, then a rounding block as the next frame
        send(8'd100, 1'b1, 1'b0);
        send(8'd100, 1'b0, 1'b1);
        send(8'd100, 1'b0, 1'b0);
        push(8'd100, 1'b1, 1'b1);
        send(8'd100, 1'b0, 1'b1);
        send(8'd100, 1'b0, 1'b0);
        send(8'd100, 1'b0, 1'b1);
        idle(3);
        drain("oddh_drain");
        check("oddh_idle_valid", 32'(down_valid), 0);
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b1);
        send(8'd2, 1'b0, 1'b0);
        push(avg4(1, 2, 2, 2), 1'b1, 1'b1);
        send(8'd2, 1'b0, 1'b1);
        idle(1);
        drain("round_drain");

        // Odd width 3x2: trailing pixel dropped, output carries no tlast
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b1);
        send(8'd4, 1'b0, 1'b0);
        push(avg4(1, 2, 4, 5), 1'b1, 1'b0);
        send(8'd5, 1'b0, 1'b0);
        send(8'd6, 1'b0, 1'b1);
        idle(2);
        drain("oddw_drain");

        // Reset mid-frame, then a fresh 4x2 frame
        send(8'd10, 1'b1, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        send(8'd40, 1'b0, 1'b1);
        send(8'd50, 1'b0, 1'b0);
        up_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_valid", 32'(down_valid), 0);
        check("mrst_data", 32'(down_data), 0);
        check("mrst_tlast", 32'(down_tlast), 0);
        check("mrst_tuser", 32'(down_tuser), 0);
        idle(1);
        frame4x2("s5");

        // Full throughput 8x2 with continuous valid
        for (int i = 0; i < 8; i++) begin
            row0[i] = 8'($urandom_range(0, 255));
            row1[i] = 8'($urandom_range(0, 255));
        end
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(row0[i], i == 0, i == 7);
            check("tp_up_ready0", 32'(up_ready), 1);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1)
                push(avg4(row0[i-1], row0[i], row1[i-1], row1[i]), i == 1, i == 7);
            send(row1[i], 1'b0, i == 7);
            check("tp_up_ready1", 32'(up_ready), 1);
        end
        check("tp_cycles", 32'(cyc - c0), 16);
        idle(1);
        drain("tp_drain");

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bfm_model_2x2.md
Name: bfm_model_2x2

Overview:
- Streaming 2x2 video downscaler behavioural/synthesizable model.
- Accepts an AXI-Stream-style pixel stream (tuser = start of frame, tlast = end of line).
- Emits one pixel per 2x2 input block, equal to the block average, on an AXI-Stream-style output with the same sideband semantics.
- Sits between a video source and sink in the downscaler pipeline; one clock domain.

Parameters:
- D_WIDTH, 8, pixel data width in bits for both upstream and downstream.
- MAX_WIDTH, 1024, maximum supported input line length in pixels; must be even. Sets line buffer depth to MAX_WIDTH/2 entries of D_WIDTH+1 bits.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_data  input  D_WIDTH  input pixel.
- up_valid  input  1  input pixel valid.
- up_tlast  input  1  last pixel of input line.
- up_tuser  input  1  first pixel of input frame.
- up_ready  output  1  block can accept an input pixel.
- down_data  output  D_WIDTH  averaged output pixel.
- down_valid  output  1  output pixel valid.
- down_tlast  output  1  last pixel of output line.
- down_tuser  output  1  first pixel of output frame.
- down_ready  input  1  sink accepts output pixel.

Behaviour:
- Input transfer: up_valid & up_ready on a rising edge. Output transfer: down_valid & down_ready.
- up_ready = !down_valid | down_ready (combinational). It is never gated by anything else.
- Counters:
  - col: pixel index in line. Bit 0 gives even/odd column.
  - row_odd: row parity.
  - pair index = col>>1.
- Transfer with up_tuser=1: treat the pixel as col=0, row_odd=0 regardless of counter state, and set the pending-SOF flag.
- After each input transfer:
  - up_tlast=1: col<=0, row_odd toggles.
  - Otherwise col increments.
- Even column: latch the pixel into the hold register.
- Odd column, even row: write hold+pixel (D_WIDTH+1 bits) to line_buf[pair].
- Odd column, odd row:
  - Compute sum = line_buf[pair] + hold + pixel (D_WIDTH+2 bits).
  - Register result into down_data on the same edge; down_valid<=1.
  - down_tlast <= up_tlast of this pixel.
  - down_tuser <= pending-SOF flag; then clear the flag.
- Latency: output valid one cycle after the transfer of the bottom-right pixel of a block.
- down_valid clears on an output transfer unless a new output is loaded on the same edge. Simultaneous load and drain is legal (full throughput).
- Output fields are stable while down_valid=1 and down_ready=0.
- Odd line width: the unpaired trailing pixel is discarded. The last emitted output of that line then has down_tlast=0.
- Odd frame height: the unpaired final row is discarded (its line buffer contents are never output). The next up_tuser restarts parity.
- Pairs with index >= MAX_WIDTH/2: no buffer write and no output.
- Reset:
  - down_valid=0, down_data=0, down_tlast=0, down_tuser=0.
  - col=0, row_odd=0, pending-SOF=0, hold=0.
  - Line buffer contents need not be cleared.
  - Reset mid-frame discards the partial frame and any pending output.

Optional Feature:
- Macro BFM_ROUNDING_EN.
- Defined: down_data = (sum+2)>>2 (round half up).
- Undefined: down_data = sum>>2 (truncate).

Test Plan:
- 4x2 frame, no backpressure.
  - Input rows 10,20,30,40 / 50,60,70,80; tuser on 10, tlast on 40 and 80.
  - Expect outputs 35 (tuser=1, tlast=0), then 55 (tuser=0, tlast=1).
  - Each output appears 1 cycle after accepting 60 and 80 respectively.
- Rounding, single 2x2 block 1,2 / 2,2 (sum 7).
  - With BFM_ROUNDING_EN: expect 2.
  - Without: expect 1.
- Backpressure: run the 4x2 frame with down_ready=0 from the first output.
  - up_ready drops after 35 is registered; 35 is held stable.
  - Raising down_ready yields 35 then 55 with no loss or duplication.
- Odd height: 2x3 frame with all pixels 100.
  - Expect exactly one output of 100 with tuser=1 and tlast=1; the third row is dropped.
  - A following frame's tuser restarts cleanly.
- Reset mid-frame: assert rst for 1 cycle after row 0 plus pixel 50 of the 4x2 frame.
  - Outputs are all zero/invalid.
  - A fresh 4x2 frame then produces 35 and 55 exactly as in the first scenario.
- Full throughput: 8x2 frame with down_ready=1 and up_valid continuous.
  - up_ready stays 1 throughout.
  - 4 outputs emitted; tlast only on the 4th.
